// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: word SRAM responder with WAIT_STATES wait cycles; DBUS_RESP_STABLE_CHECK_EN adds a request-stability checker.
module dbus_sram_responder #(
  parameter int DEPTH = 1024,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int WAIT_STATES = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus__addr,
  input  logic [3:0]  bus__wmask,
  input  logic [31:0] bus__wdata,
  output logic [31:0] bus__rdata,
  output logic        bus__rdy,
  output logic        oob,
  output logic        proto_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_wmask;
  logic [31:0] mem [DEPTH];
  logic [31:0] a, d;
  logic [3:0] m;
  logic [32:0] off;
  logic go, hit;
  logic [AW-1:0] idx;
  always_comb begin
    a = state == IDLE ? bus__addr : req_addr;
    m = state == IDLE ? bus__wmask : req_wmask;
    d = state == IDLE ? bus__wdata : req_wdata;
    go = (state == IDLE && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd1);
    off = {1'b0, a} - {1'b0, BASE};
    hit = off < 33'(4 * DEPTH);
    idx = AW'(off >> 2);
  end
  always_ff @(posedge clk)
    if (!rst && go && hit)
      for (int i = 0; i < 4; i++)
        if (m[i]) mem[idx][8*i +: 8] <= d[8*i +: 8];
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      req_addr <= bus__addr;
      req_wmask <= bus__wmask;
      req_wdata <= bus__wdata;
    end
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus__rdy <= 1'b0;
      bus__rdata <= '0;
      oob <= 1'b0;
    end else begin
      bus__rdy <= go;
      oob <= go && !hit;
      bus__rdata <= go && hit ? mem[idx] : '0;
      cnt <= state == IDLE ? 4'(WAIT_STATES) : state == WAIT ? cnt - 4'd1 : cnt;
      state <= state == IDLE ? (WAIT_STATES == 0 ? RESP : WAIT) :
               state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    end
  end
`ifdef DBUS_RESP_STABLE_CHECK_EN
  always_ff @(posedge clk)
    if (rst) proto_err <= 1'b0;
    else if (state != IDLE && {bus__addr, bus__wmask, bus__wdata} != {req_addr, req_wmask, req_wdata})
      proto_err <= 1'b1;
`else
  assign proto_err = 1'b0;
`endif
endmodule
